// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with per-entry CDB capture
// Optional ROB_STORE_ACK_EN: adds store_ack; a store at the head retires only when store_ack is high.
module reorder_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_req,
  input  logic [REG_INDEX-1:0]        alloc_dest,
  input  logic                        alloc_is_store,
  output logic                        alloc_ready,
  output logic [RB_INDEX-1:0]         alloc_index,
  input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
  input  logic [RB_SIZE-1:0]          CDB_data_valid,
  input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr,
  input  logic                        flush,
`ifdef ROB_STORE_ACK_EN
  input  logic                        store_ack,
`endif
  output logic                        commit_valid,
  output logic                        commit_is_store,
  output logic [REG_INDEX-1:0]        commit_dest,
  output logic [WORD_SIZE-1:0]        commit_data,
  output logic [WORD_SIZE-1:0]        commit_addr,
  output logic [RB_INDEX:0]           count
);

  localparam logic [RB_INDEX:0] FULL_COUNT = (RB_INDEX+1)'(RB_SIZE);

  logic [RB_SIZE-1:0]   busy;
  logic [RB_SIZE-1:0]   done;
  logic [RB_SIZE-1:0]   is_store;
  logic [REG_INDEX-1:0] dest [RB_SIZE];
  logic [WORD_SIZE-1:0] data [RB_SIZE];
  logic [WORD_SIZE-1:0] addr [RB_SIZE];
  logic [RB_INDEX-1:0]  head;
  logic [RB_INDEX-1:0]  tail;
  logic                 alloc_fire;
  logic                 commit_fire;

  assign alloc_ready     = (count != FULL_COUNT);
  assign alloc_index     = tail;
  assign alloc_fire      = alloc_req && alloc_ready;
  assign commit_valid    = busy[head] && done[head];
  assign commit_is_store = is_store[head];
  assign commit_dest     = dest[head];
  assign commit_data     = data[head];
  assign commit_addr     = addr[head];

`ifdef ROB_STORE_ACK_EN
  assign commit_fire = commit_valid && (!is_store[head] || store_ack);
`else
  assign commit_fire = commit_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      done     <= '0;
      is_store <= '0;
      for (int k = 0; k < RB_SIZE; k++) begin
        dest[k] <= '0;
        data[k] <= '0;
        addr[k] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else begin
      for (int k = 0; k < RB_SIZE; k++) begin
        if (CDB_data_valid[k] && busy[k] && !done[k]) begin
          done[k] <= 1'b1;
          data[k] <= CDB_data_data[k*WORD_SIZE +: WORD_SIZE];
          if (is_store[k])
            addr[k] <= CDB_data_addr[k*WORD_SIZE +: WORD_SIZE];
        end
      end
      if (commit_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + RB_INDEX'(1);
      end
      // Written last so a same-cycle capture to the tail entry loses.
      if (alloc_fire) begin
        busy[tail]     <= 1'b1;
        done[tail]     <= 1'b0;
        dest[tail]     <= alloc_dest;
        is_store[tail] <= alloc_is_store;
        tail           <= tail + RB_INDEX'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + (RB_INDEX+1)'(1);
        2'b01:   count <= count - (RB_INDEX+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - queue-model bench for reorder_buffer
// Set ROB_STORE_ACK_EN to exercise the store acknowledge path.
module tb_reorder_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         alloc_req = 1'b0;
  logic [4:0]   alloc_dest = '0;
  logic         alloc_is_store = 1'b0;
  logic         alloc_ready;
  logic [2:0]   alloc_index;
  logic [255:0] cdb_data = '0;
  logic [7:0]   cdb_valid = '0;
  logic [255:0] cdb_addr = '0;
  logic         flush = 1'b0;
`ifdef ROB_STORE_ACK_EN
  logic         store_ack = 1'b1;
`endif
  logic         commit_valid;
  logic         commit_is_store;
  logic [4:0]   commit_dest;
  logic [31:0]  commit_data;
  logic [31:0]  commit_addr;
  logic [3:0]   count;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_dest     (alloc_dest),
    .alloc_is_store (alloc_is_store),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .CDB_data_data  (cdb_data),
    .CDB_data_valid (cdb_valid),
    .CDB_data_addr  (cdb_addr),
    .flush          (flush),
`ifdef ROB_STORE_ACK_EN
    .store_ack      (store_ack),
`endif
    .commit_valid   (commit_valid),
    .commit_is_store(commit_is_store),
    .commit_dest    (commit_dest),
    .commit_data    (commit_data),
    .commit_addr    (commit_addr),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Model: occupied entries in allocation order, oldest at the front.
  typedef struct {
    int          idx;
    logic [4:0]  dest;
    bit          st;
    bit          done;
    logic [31:0] data;
    logic [31:0] addr;
  } ent_t;

  ent_t mq[$];
  int   m_tail = 0;

  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      bit   retire;
      bit   room;
      ent_t e;
      retire = (mq.size() > 0) && mq[0].done;
`ifdef ROB_STORE_ACK_EN
      if (retire && mq[0].st && !store_ack) retire = 1'b0;
`endif
      room = (mq.size() < 8);
      foreach (mq[i]) begin
        if (cdb_valid[mq[i].idx] && !mq[i].done) begin
          mq[i].done = 1'b1;
          mq[i].data = cdb_data[mq[i].idx*32 +: 32];
          if (mq[i].st) mq[i].addr = cdb_addr[mq[i].idx*32 +: 32];
        end
      end
      if (retire) void'(mq.pop_front());
      if (alloc_req && room) begin
        e.idx = m_tail; e.dest = alloc_dest; e.st = alloc_is_store;
        e.done = 1'b0; e.data = '0; e.addr = '0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % 8;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < 8));
      chk("alloc_index", 32'(alloc_index), 32'(m_tail));
      chk("commit_valid", 32'(commit_valid), 32'((mq.size() > 0) && mq[0].done));
      if (mq.size() > 0 && mq[0].done) begin
        chk("commit_dest", 32'(commit_dest), 32'(mq[0].dest));
        chk("commit_data", commit_data, mq[0].data);
        chk("commit_is_store", 32'(commit_is_store), 32'(mq[0].st));
        if (mq[0].st) chk("commit_addr", commit_addr, mq[0].addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    alloc_is_store = 1'b0;
    cdb_valid = '0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_cdb(input int k, input logic [31:0] d, input logic [31:0] a);
    cdb_valid[k] = 1'b1;
    cdb_data[k*32 +: 32] = d;
    cdb_addr[k*32 +: 32] = a;
  endtask

  task automatic do_alloc(input logic [4:0] d, input bit st);
    alloc_req = 1'b1;
    alloc_dest = d;
    alloc_is_store = st;
    tick();
  endtask

  initial begin
    do_reset();
    model_on = 1'b1;
    chk("rst alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst alloc_index", 32'(alloc_index), 32'd0);
    chk("rst commit_valid", 32'(commit_valid), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst commit_data", commit_data, 32'd0);
    chk("rst commit_dest", 32'(commit_dest), 32'd0);
    chk("rst commit_addr", commit_addr, 32'd0);

    // Single instruction round trip.
    do_alloc(5'd3, 1'b0);
    set_cdb(0, 32'h0000_00AA, 32'h0);
    tick();
    chk("single commit_valid", 32'(commit_valid), 32'd1);
    chk("single commit_dest", 32'(commit_dest), 32'd3);
    chk("single commit_data", commit_data, 32'hAA);
    tick();
    chk("single count", 32'(count), 32'd0);

    // Fill, overflow attempt, then commit with a blocked allocate.
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(5'(i + 1), 1'b0);
    chk("full alloc_ready", 32'(alloc_ready), 32'd0);
    chk("full count", 32'(count), 32'd8);
    do_alloc(5'd31, 1'b0);
    chk("ninth count", 32'(count), 32'd8);
    chk("ninth alloc_index", 32'(alloc_index), 32'd0);
    set_cdb(0, 32'h5A, 32'h0);
    tick();
    do_alloc(5'd20, 1'b0);
    chk("full commit count", 32'(count), 32'd7);
    chk("full commit alloc_index", 32'(alloc_index), 32'd0);
    set_cdb(1, 32'h6B, 32'h0);
    tick();
    do_alloc(5'd21, 1'b0);
    chk("alloc+commit count", 32'(count), 32'd7);
    chk("alloc+commit alloc_index", 32'(alloc_index), 32'd1);

    // Out-of-order completion retires in order; stale CDB bits ignored.
    do_reset();
    do_alloc(5'd10, 1'b0);
    do_alloc(5'd11, 1'b0);
    set_cdb(1, 32'h11, 32'h0);
    set_cdb(5, 32'hDEAD, 32'h0);
    tick();
    chk("ooo head waits", 32'(commit_valid), 32'd0);
    set_cdb(0, 32'h10, 32'h0);
    set_cdb(1, 32'hFF, 32'h0);
    tick();
    chk("ooo first dest", 32'(commit_dest), 32'd10);
    chk("ooo first data", commit_data, 32'h10);
    tick();
    chk("ooo second valid", 32'(commit_valid), 32'd1);
    chk("ooo second dest", 32'(commit_dest), 32'd11);
    chk("ooo second data", commit_data, 32'h11);
    tick();
    chk("ooo drained", 32'(count), 32'd0);

    // Wrap-around: six in, six out, four more at 6,7,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) do_alloc(5'(i), 1'b0);
    for (int i = 0; i < 6; i++) set_cdb(i, 32'(i * 256 + i), 32'h0);
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("wrap empty", 32'(count), 32'd0);
    chk("wrap index 6", 32'(alloc_index), 32'd6);
    set_cdb(6, 32'hBAD, 32'h0);
    do_alloc(5'd16, 1'b0);
    chk("wrap alloc wins", 32'(commit_valid), 32'd0);
    chk("wrap index 7", 32'(alloc_index), 32'd7);
    do_alloc(5'd17, 1'b1);
    chk("wrap index 0", 32'(alloc_index), 32'd0);
    do_alloc(5'd18, 1'b0);
    chk("wrap index 1", 32'(alloc_index), 32'd1);
    do_alloc(5'd19, 1'b0);
    chk("wrap index 2", 32'(alloc_index), 32'd2);
    set_cdb(6, 32'h606, 32'h0);
    set_cdb(7, 32'h707, 32'h700);
    set_cdb(0, 32'h1000, 32'h0);
    set_cdb(1, 32'h1101, 32'h0);
    tick();
    chk("wrap data 6", commit_data, 32'h606);
    tick();
    chk("wrap data 7", commit_data, 32'h707);
    chk("wrap addr 7", commit_addr, 32'h700);
    tick();
    chk("wrap data 0", commit_data, 32'h1000);
    tick();
    chk("wrap data 1", commit_data, 32'h1101);
    tick();

    // Flush overrides capture and allocate.
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(5'(i + 4), 1'b0);
    flush = 1'b1;
    set_cdb(0, 32'h77, 32'h0);
    alloc_req = 1'b1;
    tick();
    chk("flush count", 32'(count), 32'd0);
    chk("flush commit_valid", 32'(commit_valid), 32'd0);
    chk("flush alloc_index", 32'(alloc_index), 32'd0);

`ifdef ROB_STORE_ACK_EN
    // Store at head waits for store_ack.
    do_reset();
    store_ack = 1'b0;
    do_alloc(5'd4, 1'b1);
    set_cdb(0, 32'h55, 32'h100);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ack hold valid", 32'(commit_valid), 32'd1);
      chk("ack hold addr", commit_addr, 32'h100);
      tick();
    end
    chk("ack hold count", 32'(count), 32'd1);
    store_ack = 1'b1;
    tick();
    chk("ack retire count", 32'(count), 32'd0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
